mini_alu_pipe: RTL
==================

# mini_alu_pipe

Parametrised two-stage (fetch/execute) mini processor core. Successor to the fixed 16-bit MiniAlu:
- Generic data width, register-file depth and instruction-pointer width.
- Adds logic, shift, multiply, equality-branch and halt operations.
- Replaces the ad-hoc LCD gating with a valid/ready output port that stalls the pipeline.

It sits between an external asynchronous instruction ROM and the LED/LCD peripherals at top level.

## Interface
- DATA_WIDTH, 16, register/ALU width (≥8)
- RF_DEPTH, 256, register count; power of two, ≤256; index = low log2(RF_DEPTH) bits of an 8-bit address field
- IP_WIDTH, 8, instruction-pointer width (≥8); branch targets are the 8-bit destination field, zero-extended
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- iRun  in  1  level; low holds the core idle (replaces modules-loaded gating)
- oInstrAddr  out  IP_WIDTH  ROM address (= IP register)
- iInstruction  in  28  ROM data, combinational from oInstrAddr; [27:24] op, [23:16] dst, [15:8] src1, [7:0] src0
- oLed  out  8  LED register
- oPerValid  out  1  peripheral write request
- oPerData  out  8  peripheral byte; 0 when oPerValid low
- iPerReady  in  1  peripheral accepts when high together with oPerValid
- oHalted  out  1  core halted
- oRetire  out  1  one-cycle pulse per executed (non-squashed, non-NOP) instruction

## Operation
- State: IP, IR (28 b), oLed, halted flag, register file (not reset; programs initialise with STO).
- Execute stage decodes IR:
  - Register reads are combinational on IR src1/src0 (A = R[src1], B = R[src0]).
  - The write to R[dst] lands at the clock edge.
- Opcodes:
  - 0 NOP
  - 1 LED: oLed ← A[7:0]
  - 2 BLE: branch to dst if A ≤ B, unsigned
  - 3 STO: R[dst] ← {src1,src0}, zero-extended/truncated to DATA_WIDTH
  - 4 ADD: A+B
  - 5 JMP: branch to dst
  - 6 SUB: A−B
  - 7 OUT: peripheral write of A[7:0]
  - 8 AND
  - 9 OR
  - A SHL: A<<B
  - B SHR: A>>B (logical)
  - C MUL: low DATA_WIDTH bits of A·B
  - D BEQ: branch to dst if A == B
  - E HALT
  - F: treated as NOP
- Arithmetic:
  - Results wrap modulo 2^DATA_WIDTH, no flags.
  - Shifts: if B ≥ DATA_WIDTH, the result is 0.
- Branch taken: IP ← zero-extended dst, IR ← NOP (squash the fetched instruction). Not taken: normal advance.
- OUT stall:
  - While IR holds OUT: oPerValid = 1, oPerData = A[7:0].
  - If iPerReady = 0: IP and IR hold, data stays stable.
  - If iPerReady = 1: transfer completes at that edge and the pipeline advances.
- iRun low, and no OUT pending: at each edge IP ← 0, IR ← NOP.
- iRun low with OUT pending: the OUT completes first, then the idle rule applies.
- HALT: oHalted ← 1, IR ← NOP, IP frozen. Only Reset clears it; iRun is ignored while halted.
- IP wraps from 2^IP_WIDTH−1 to 0.

## Timing
- Reset (async, immediate): IP = 0, IR = NOP, oLed = 0, oHalted = 0, oPerValid = 0, oPerData = 0, oRetire = 0.
- Fetch/execute timing:
  - Instruction at address A is fetched in cycle n (oInstrAddr = A) and captured into IR at the end of n.
  - It executes in cycle n+1; the register write, LED update and IP redirect happen at the end of n+1.
- Back-to-back dependent instructions have no hazard: writes at end of n+1 are read combinationally in n+2.
- Branch penalty is 1 bubble: the target instruction executes 2 cycles after the branch executes.
- oRetire is combinational in the execute cycle of the retiring instruction:
  - High for an OUT only in its accepting cycle.
  - Low for squashed slots and NOP.
- Reset asserted mid-OUT: oPerValid drops immediately and no transfer is counted.
- Simultaneous Reset and any event: Reset wins.

## Test plan
- After reset, iRun = 1, program STO R1,5; STO R2,3; ADD R3,R1,R2; LED R3 → oLed = 0x08 on the edge ending cycle 4; oRetire high 4 cycles.
- SUB 3−5 with DATA_WIDTH = 16 → R = 0xFFFE. MUL 0x0100·0x0100 → 0. SHL by 16 → 0. SHR 0x8000 by 15 → 1.
- Loop: STO R1,0; STO R2,1; STO R3,3; ADD R1,R1,R2; BLE to 3 if R1 ≤ R3; LED R1 → oLed = 4; one squashed slot per taken branch, checked via oInstrAddr/oRetire.
- OUT 0x41 with iPerReady held low 5 cycles:
  - oPerValid high and oPerData = 0x41 stable, oInstrAddr frozen.
  - iPerReady pulse → exactly one transfer, IP advances.
- HALT then toggle iRun → oHalted = 1 and oInstrAddr constant. Async Reset mid-program → all outputs 0 within the same cycle, restart from address 0.
- DATA_WIDTH = 8, RF_DEPTH = 16 build: STO R17,0x1234 writes R1 = 0x34; ADD 0xFF+1 → 0x00.

Source files
------------

// File: rtl/mini_alu_pipe.sv
// rtl/mini_alu_pipe.sv - two-stage fetch/execute mini core with stalling peripheral port
module mini_alu_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int RF_DEPTH   = 256,
    parameter int IP_WIDTH   = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iRun,
    output logic [IP_WIDTH-1:0] oInstrAddr,
    input  logic [27:0]         iInstruction,
    output logic [7:0]          oLed,
    output logic                oPerValid,
    output logic [7:0]          oPerData,
    input  logic                iPerReady,
    output logic                oHalted,
    output logic                oRetire
);
    localparam int AW = $clog2(RF_DEPTH);
    localparam logic [DATA_WIDTH-1:0] SHIFT_LIMIT = DATA_WIDTH'(DATA_WIDTH);
    localparam logic [27:0] IR_NOP = 28'h0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LED  = 4'h1;
    localparam logic [3:0] OP_BLE  = 4'h2;
    localparam logic [3:0] OP_STO  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_BEQ  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_RSV  = 4'hF;

    logic [IP_WIDTH-1:0]   ip_q, ip_d;
    logic [27:0]           ir_q, ir_d;
    logic [7:0]            led_q, led_d;
    logic                  halted_q, halted_d;
    logic [DATA_WIDTH-1:0] rf_q [RF_DEPTH];

    logic [3:0]            op;
    logic [AW-1:0]         dst_idx, a_idx, b_idx;
    logic [DATA_WIDTH-1:0] a, b, result;
    logic                  wr_en, taken, is_out, out_stall;

    always_comb begin
        op      = ir_q[27:24];
        dst_idx = ir_q[16 +: AW];
        a_idx   = ir_q[8 +: AW];
        b_idx   = ir_q[0 +: AW];
        a       = rf_q[a_idx];
        b       = rf_q[b_idx];
        result  = '0;
        wr_en   = 1'b0;
        taken   = 1'b0;
        case (op)
            OP_BLE: taken = (a <= b);
            OP_STO: begin wr_en = 1'b1; result = DATA_WIDTH'(ir_q[15:0]); end
            OP_ADD: begin wr_en = 1'b1; result = a + b; end
            OP_JMP: taken = 1'b1;
            OP_SUB: begin wr_en = 1'b1; result = a - b; end
            OP_AND: begin wr_en = 1'b1; result = a & b; end
            OP_OR:  begin wr_en = 1'b1; result = a | b; end
            OP_SHL: begin wr_en = 1'b1; result = (b >= SHIFT_LIMIT) ? '0 : (a << b); end
            OP_SHR: begin wr_en = 1'b1; result = (b >= SHIFT_LIMIT) ? '0 : (a >> b); end
            OP_MUL: begin wr_en = 1'b1; result = a * b; end
            OP_BEQ: taken = (a == b);
            default: ;
        endcase
    end

    // An OUT waiting on the peripheral freezes fetch and execute together.
    always_comb begin
        is_out    = (op == OP_OUT);
        out_stall = is_out && !iPerReady;
        ip_d      = ip_q;
        ir_d      = ir_q;
        led_d     = led_q;
        halted_d  = halted_q;
        if (halted_q) begin
            ir_d = IR_NOP;
        end else if (op == OP_HALT) begin
            halted_d = 1'b1;
            ir_d     = IR_NOP;
        end else if (!out_stall) begin
            if (op == OP_LED) begin
                led_d = a[7:0];
            end
            if (!iRun) begin
                ip_d = '0;
                ir_d = IR_NOP;
            end else if (taken) begin
                ip_d = IP_WIDTH'(ir_q[23:16]);
                ir_d = IR_NOP;
            end else begin
                ip_d = ip_q + IP_WIDTH'(1);
                ir_d = iInstruction;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ip_q     <= '0;
            ir_q     <= IR_NOP;
            led_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            ip_q     <= ip_d;
            ir_q     <= ir_d;
            led_q    <= led_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en && !halted_q) begin
            rf_q[dst_idx] <= result;
        end
    end

    assign oInstrAddr = ip_q;
    assign oLed       = led_q;
    assign oHalted    = halted_q;
    assign oPerValid  = is_out;
    assign oPerData   = is_out ? a[7:0] : 8'h00;
    assign oRetire    = !halted_q && (op != OP_NOP) && (op != OP_RSV) && !out_stall;
endmodule
